// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//
// Writer side of the network weight-load interface. Accepts a ready/valid
// stream of fixed-point weight words and shifts each accepted word into exactly
// one node of the two-layer network. It does this by driving a one-hot
// per-node shift enable (we) together with the shared weight bus (bus).
//
// Load order: layer-1 nodes 0..SL1-1 take SX words each, then layer-2 nodes
// 0..SL2-1 take SL1 words each. Layer-1 node j is enabled by we[ND-SL1+j].
// Layer-2 node j is enabled by we[j].
//
// Ports
//   clk      system clock
//   rst      asynchronous, active-high reset
//   start    begin a full load (sampled in IDLE only)
//   abort    synchronous cancel of a load in progress (also wins over start)
//   s_data   signed weight word from the stream
//   s_valid  s_data is valid
//   s_ready  loader accepts s_data this cycle (high throughout LOAD)
//   we       one-hot node shift enable, valid the cycle after a handshake
//   bus      weight word, valid alongside we; holds its last value otherwise
//   busy     high in LOAD and DONE
//   done     one-cycle pulse, coincident with the final we pulse
// -----------------------------------------------------------------------------
module weight_loader #(
  parameter int N   = 16,
  parameter int SX  = 4,
  parameter int SL1 = 4,
  parameter int SL2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic signed [N-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [SL1+SL2-1:0]  we,
  output logic signed [N-1:0] bus,
  output logic                busy,
  output logic                done
);

  localparam int ND   = SL1 + SL2;
  localparam int WT   = SX*SL1 + SL1*SL2;
  localparam int MAXF = (SX > SL1) ? SX : SL1;
  localparam int NW   = $clog2(ND + 1);
  localparam int WW   = $clog2(MAXF + 1);
  localparam int TW   = $clog2(WT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [NW-1:0]   node;
  logic [WW-1:0]   word;
  logic [TW-1:0]   total;

  logic            hs_p0;
  logic            last_word_p0;
  logic            last_total_p0;

  // Number of words a node takes: layer-1 nodes see the network inputs,
  // layer-2 nodes see the layer-1 outputs.
  function automatic logic [WW-1:0] fanin(input logic [NW-1:0] nd);
    if (nd < NW'(SL1))
      fanin = WW'(SX);
    else
      fanin = WW'(SL1);
  endfunction

  // Map the load-order node index onto the network's enable bit. Layer 1
  // occupies the upper SL1 bits, layer 2 the lower SL2 bits.
  function automatic logic [ND-1:0] node_sel(input logic [NW-1:0] nd);
    int b;
    node_sel = '0;
    for (int i = 0; i < ND; i++) begin
      b = (i < SL1) ? (ND - SL1 + i) : (i - SL1);
      if (nd == NW'(i))
        node_sel[b] = 1'b1;
    end
  endfunction

  // ---- stage p0: handshake decode on the current counters ----
  // s_ready is a registered copy of (state == LOAD), so it alone gates the
  // handshake.
  assign hs_p0         = s_ready && s_valid;
  assign last_word_p0  = (word == fanin(node) - WW'(1));
  assign last_total_p0 = (total == TW'(WT - 1));

  // ---- stage p1: registered control, enable and bus ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      node    <= '0;
      word    <= '0;
      total   <= '0;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      we      <= '0;
      bus     <= '0;
    end else begin
      // Enables and done are single-cycle strobes unless re-armed below.
      we   <= '0;
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !abort) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b1;
            node    <= '0;
            word    <= '0;
            total   <= '0;
          end
        end

        LOAD: begin
          if (abort) begin
            // The network keeps whatever was shifted in so far; a restart
            // begins again at word 1.
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            node    <= '0;
            word    <= '0;
            total   <= '0;
          end else if (hs_p0) begin
            bus   <= s_data;
            we    <= node_sel(node);
            total <= total + TW'(1);
            if (last_word_p0) begin
              word <= '0;
              node <= node + NW'(1);
            end else begin
              word <= word + WW'(1);
            end
            if (last_total_p0) begin
              // Final word: its we pulse and done share the DONE cycle.
              state   <= DONE;
              s_ready <= 1'b0;
              done    <= 1'b1;
              node    <= '0;
              word    <= '0;
              total   <= '0;
            end
          end
        end

        DONE: begin
          // Abort here has the same outcome, so no separate branch.
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
          node    <= '0;
          word    <= '0;
          total   <= '0;
        end

        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
          node    <= '0;
          word    <= '0;
          total   <= '0;
        end
      endcase
    end
  end

endmodule
